// File: rtl/sisc_mem_resp.sv
// Word-addressed single-port memory responder for the SISC control FSM.
// Valid/ready request and response channels, fixed programmable latency, one transaction in flight.
module sisc_mem_resp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic                err_reg;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                access;
    logic                in_range;
    logic [IDX_W-1:0]    idx;

    assign accept   = req_valid && (state_reg == IDLE);
    assign access   = (state_reg == BUSY) && (cnt_reg == 4'd0);
    // Zero-extended compare so the full address width is checked with no aliasing.
    assign in_range = {1'b0, addr_reg} < (ADDR_W + 1)'(DEPTH);
    assign idx      = addr_reg[IDX_W-1:0];

    assign resp_rdata = rdata_reg;
    assign resp_err   = err_reg;

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                cnt_reg <= 4'(LATENCY - 1);
            end else if ((state_reg == BUSY) && (cnt_reg != 4'd0)) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (access) begin
                if (in_range) begin
                    rdata_reg <= we_reg ? wdata_reg : mem[idx];
                    err_reg   <= 1'b0;
                end else begin
                    rdata_reg <= '0;
                    err_reg   <= 1'b1;
                end
            end
        end
    end

    // Request fields are latched once at acceptance; later req_* activity is ignored.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
        end
    end

    // Storage keeps its contents across reset; a reset on the commit edge cancels the write.
    always_ff @(posedge clk) begin
        if (!rst && access && we_reg && in_range) begin
            mem[idx] <= wdata_reg;
        end
    end

endmodule

// File: tb/tb_sisc_mem_resp.sv
// Directed bench for sisc_mem_resp: one instance at LATENCY=2, one at LATENCY=1
// for the back-to-back throughput case.
module tb_sisc_mem_resp;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err;
    logic [15:0] a_req_addr;
    logic [31:0] a_req_wdata, a_resp_rdata;

    logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
    logic [15:0] b_req_addr;
    logic [31:0] b_req_wdata, b_resp_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sisc_mem_resp #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .LATENCY(2)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (a_req_valid),
        .req_ready  (a_req_ready),
        .req_we     (a_req_we),
        .req_addr   (a_req_addr),
        .req_wdata  (a_req_wdata),
        .resp_valid (a_resp_valid),
        .resp_ready (a_resp_ready),
        .resp_rdata (a_resp_rdata),
        .resp_err   (a_resp_err)
    );

    sisc_mem_resp #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .LATENCY(1)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_we     (b_req_we),
        .req_addr   (b_req_addr),
        .req_wdata  (b_req_wdata),
        .resp_valid (b_resp_valid),
        .resp_ready (b_resp_ready),
        .resp_rdata (b_resp_rdata),
        .resp_err   (b_resp_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction on instance A with resp_ready held high.
    task automatic a_txn(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_e, input string tag);
        int n;
        a_req_valid = 1'b1;
        a_req_we    = we;
        a_req_addr  = addr;
        a_req_wdata = wd;
        chk({tag, "_req_ready"}, 64'(a_req_ready), 64'd1);
        step();
        a_req_valid = 1'b0;
        a_req_we    = 1'b1;
        a_req_addr  = 16'h0000;
        a_req_wdata = 32'hFFFF_FFFF;
        n = 0;
        while (!a_resp_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd2);
        chk({tag, "_rdata"}, 64'(a_resp_rdata), 64'(exp_d));
        chk({tag, "_err"}, 64'(a_resp_err), 64'(exp_e));
        chk({tag, "_busy_ready"}, 64'(a_req_ready), 64'd0);
        step();
        chk({tag, "_done_valid"}, 64'(a_resp_valid), 64'd0);
        chk({tag, "_done_ready"}, 64'(a_req_ready), 64'd1);
        a_req_we = 1'b0;
    endtask

    initial begin
        int acc[$];
        int rsp[$];

        rst = 1'b1;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_resp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk("reset_req_ready", 64'(a_req_ready), 64'd1);
        chk("reset_resp_valid", 64'(a_resp_valid), 64'd0);
        chk("reset_rdata", 64'(a_resp_rdata), 64'd0);
        chk("reset_err", 64'(a_resp_err), 64'd0);

        a_txn(1'b1, 16'h0010, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "store_10");
        chk("store_10_rdata_held", 64'(a_resp_rdata), 64'hDEADBEEF);
        a_txn(1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, "load_10");

        a_txn(1'b1, 16'h0000, 32'h22222222, 32'h22222222, 1'b0, "store_00");
        a_txn(1'b1, 16'h00FF, 32'h11111111, 32'h11111111, 1'b0, "store_ff");
        a_txn(1'b0, 16'h0100, 32'h0, 32'h0, 1'b1, "load_100");
        chk("load_100_err_held", 64'(a_resp_err), 64'd1);
        a_txn(1'b1, 16'h0100, 32'h0BAD0BAD, 32'h0, 1'b1, "store_100");
        a_txn(1'b0, 16'hFFFF, 32'h0, 32'h0, 1'b1, "load_ffff");
        a_txn(1'b0, 16'h0000, 32'h0, 32'h22222222, 1'b0, "load_00");
        a_txn(1'b0, 16'h00FF, 32'h0, 32'h11111111, 1'b0, "load_ff");
        a_txn(1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, "load_10_again");

        // Backpressure: response held while resp_ready is low, stray requests ignored.
        a_resp_ready = 1'b0;
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 16'h0010;
        step();
        a_req_valid = 1'b0;
        step();
        step();
        chk("bp_valid_start", 64'(a_resp_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 16'h0010; a_req_wdata = 32'h00000BAD;
            step();
            chk("bp_valid", 64'(a_resp_valid), 64'd1);
            chk("bp_rdata", 64'(a_resp_rdata), 64'hDEADBEEF);
            chk("bp_err", 64'(a_resp_err), 64'd0);
            chk("bp_req_ready", 64'(a_req_ready), 64'd0);
        end
        a_req_valid = 1'b0; a_req_we = 1'b0;
        a_resp_ready = 1'b1;
        step();
        chk("bp_done_valid", 64'(a_resp_valid), 64'd0);
        chk("bp_done_ready", 64'(a_req_ready), 64'd1);
        a_txn(1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, "bp_no_stray_store");

        // Reset on the commit edge of a store must cancel it.
        a_txn(1'b1, 16'h0020, 32'h00000005, 32'h00000005, 1'b0, "store_20");
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 16'h0020; a_req_wdata = 32'hAAAA5555;
        step();
        a_req_valid = 1'b0; a_req_we = 1'b0;
        step();
        chk("rstbusy_valid_before", 64'(a_resp_valid), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstbusy_valid", 64'(a_resp_valid), 64'd0);
        chk("rstbusy_ready", 64'(a_req_ready), 64'd1);
        chk("rstbusy_rdata", 64'(a_resp_rdata), 64'd0);
        repeat (3) begin
            step();
            chk("rstbusy_no_resp", 64'(a_resp_valid), 64'd0);
        end
        a_txn(1'b0, 16'h0020, 32'h0, 32'h00000005, 1'b0, "load_20_after_rst");

        // LATENCY=1 instance: one store, then back-to-back loads with req_valid held.
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 16'h0003; b_req_wdata = 32'h33333333;
        chk("b_store_ready", 64'(b_req_ready), 64'd1);
        step();
        b_req_valid = 1'b0; b_req_we = 1'b0;
        step();
        chk("b_store_valid", 64'(b_resp_valid), 64'd1);
        chk("b_store_rdata", 64'(b_resp_rdata), 64'h33333333);
        step();
        chk("b_store_done_ready", 64'(b_req_ready), 64'd1);

        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 16'h0003;
        for (int c = 0; c < 12; c++) begin
            if (b_req_ready) acc.push_back(c);
            if (b_resp_valid) begin
                rsp.push_back(c);
                chk("b2b_rdata", 64'(b_resp_rdata), 64'h33333333);
                chk("b2b_err", 64'(b_resp_err), 64'd0);
            end
            step();
        end
        b_req_valid = 1'b0;
        chk("b2b_accepts", 64'(acc.size()), 64'd4);
        chk("b2b_resps", 64'(rsp.size()), 64'd4);
        if (acc.size() == 4 && rsp.size() == 4) begin
            chk("b2b_first_accept", 64'(acc[0]), 64'd0);
            for (int i = 0; i < 4; i++) begin
                if (i > 0) chk("b2b_spacing", 64'(acc[i] - acc[i-1]), 64'd3);
                chk("b2b_resp_delay", 64'(rsp[i] - acc[i]), 64'd2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
